imem_loader: RTL

//  Writer side of the instruction memory: receives a byte-serial program image

---
 rtl/imem_loader.sv | 136 +++++++++++++
 1 files changed

// File: rtl/imem_loader.sv
// rtl/imem_loader.sv - byte-stream program image loader into 32-bit instruction memory
// Parses a 2-byte word count, then packs little-endian bytes into words and writes them.
module imem_loader #(
    parameter int ADDR_WIDTH = 8
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic [7:0]  ByteIn,
    input  logic        ByteValid,
    output logic        ByteReady,
    input  logic        Restart,
    output logic        MemWrite,
    output logic [31:0] MemAddress,
    output logic [31:0] MemWriteData,
    output logic        CpuHold,
    output logic        Done,
    output logic        Error,
    output logic [15:0] WordsLoaded
);

    typedef enum logic [2:0] {
        S_LEN0,
        S_LEN1,
        S_DATA,
        S_WRITE,
        S_DONE,
        S_ERR
    } state_t;

    // 17 bits so a count of 65535 still compares correctly against 2**16.
    localparam logic [16:0] CAPACITY = 17'd1 << ADDR_WIDTH;

    state_t      state;
    state_t      state_next;
    logic [15:0] count;
    logic [1:0]  byte_idx;
    logic [23:0] word_buf;
    logic        xfer;
    logic [15:0] len_full;

    assign xfer     = ByteValid & ByteReady;
    assign len_full = {ByteIn, count[7:0]};

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state <= S_LEN0;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        ByteReady  = 1'b0;
        MemWrite   = 1'b0;
        CpuHold    = 1'b1;
        Done       = 1'b0;
        Error      = 1'b0;
        case (state)
            S_LEN0: begin
                ByteReady = 1'b1;
                if (xfer) state_next = S_LEN1;
            end
            S_LEN1: begin
                ByteReady = 1'b1;
                if (xfer) begin
                    if (len_full == 16'd0)                  state_next = S_DONE;
                    else if ({1'b0, len_full} > CAPACITY)   state_next = S_ERR;
                    else                                    state_next = S_DATA;
                end
            end
            S_DATA: begin
                ByteReady = 1'b1;
                if (xfer && byte_idx == 2'd3) state_next = S_WRITE;
            end
            S_WRITE: begin
                MemWrite = 1'b1;
                if (WordsLoaded + 16'd1 == count) state_next = S_DONE;
                else                              state_next = S_DATA;
            end
            S_DONE: begin
                Done    = 1'b1;
                CpuHold = 1'b0;
                if (Restart) state_next = S_LEN0;
            end
            S_ERR: begin
                Error = 1'b1;
                if (Restart) state_next = S_LEN0;
            end
            default: state_next = S_LEN0;
        endcase
    end

    // Address and data are latched with the 4th byte so they are valid during
    // WRITE and keep the last written values afterwards.
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            count        <= 16'd0;
            byte_idx     <= 2'd0;
            word_buf     <= 24'd0;
            MemAddress   <= 32'd0;
            MemWriteData <= 32'd0;
            WordsLoaded  <= 16'd0;
        end else begin
            case (state)
                S_LEN0: if (xfer) count[7:0] <= ByteIn;
                S_LEN1: if (xfer) count[15:8] <= ByteIn;
                S_DATA: begin
                    if (xfer) begin
                        byte_idx <= byte_idx + 2'd1;
                        case (byte_idx)
                            2'd0: word_buf[7:0]   <= ByteIn;
                            2'd1: word_buf[15:8]  <= ByteIn;
                            2'd2: word_buf[23:16] <= ByteIn;
                            default: begin
                                MemAddress   <= {{(30 - ADDR_WIDTH){1'b0}},
                                                 WordsLoaded[ADDR_WIDTH-1:0], 2'b00};
                                MemWriteData <= {ByteIn, word_buf};
                            end
                        endcase
                    end
                end
                S_WRITE: WordsLoaded <= WordsLoaded + 16'd1;
                S_DONE, S_ERR: begin
                    if (Restart) begin
                        WordsLoaded <= 16'd0;
                        count       <= 16'd0;
                        byte_idx    <= 2'd0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
